// File: rtl/timing_gen_pkg.sv
// Shared CPU-model constants for the timing generator and control.
// The short LD cycle is selected by TIMING_SHORT_LD_EN.
package timing_gen_pkg;

    localparam int OP_W          = 4;
    localparam int BEAT_COUNT    = 8;
    localparam int SHORT_LD_LAST = 5;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LD  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_AND = 4'h4;
    localparam logic [OP_W-1:0] OP_OR  = 4'h5;

    typedef enum logic {
        IDLE,
        BEAT
    } state_t;

    // Anything above OP_OR is undefined; 4'h0 is a legal no-op.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return op > OP_OR;
    endfunction

endpackage

// File: rtl/timing_gen_if.sv
// Instruction/beat bus between IR-side control (master) and the timing generator (slave).
interface timing_gen_if;
    import timing_gen_pkg::*;

    logic            run;
    logic            ir_valid;
    logic [OP_W-1:0] ir_op;
    logic [7:0]      beat;
    logic            dec_ld;
    logic            dec_add;
    logic            dec_sub;
    logic            dec_and;
    logic            dec_or;
    logic            cycle_end;
    logic            illegal;

    modport master (
        output run, ir_valid, ir_op,
        input  beat, dec_ld, dec_add, dec_sub, dec_and, dec_or, cycle_end, illegal
    );

    modport slave (
        input  run, ir_valid, ir_op,
        output beat, dec_ld, dec_add, dec_sub, dec_and, dec_or, cycle_end, illegal
    );
endinterface

// File: rtl/timing_gen_op_decode.sv
// Combinational opcode decode: at most one instruction line high, illegal for undefined opcodes.
module op_decode
    import timing_gen_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            ld,
    output logic            add,
    output logic            sub,
    output logic            and_op,
    output logic            or_op,
    output logic            illegal
);

    always_comb begin
        ld      = 1'b0;
        add     = 1'b0;
        sub     = 1'b0;
        and_op  = 1'b0;
        or_op   = 1'b0;
        illegal = op_is_illegal(op);
        case (op)
            OP_LD:   ld     = 1'b1;
            OP_ADD:  add    = 1'b1;
            OP_SUB:  sub    = 1'b1;
            OP_AND:  and_op = 1'b1;
            OP_OR:   or_op  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/timing_gen.sv
// Beat sequencer producing one-hot T0..T7 instruction cycles plus opcode decode.
// Defining TIMING_SHORT_LD_EN ends LD cycles at T5 instead of T7.
module timing_gen
    import timing_gen_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    timing_gen_if.slave bus
);

`ifdef TIMING_SHORT_LD_EN
    localparam bit SHORT_LD_EN = 1'b1;
`else
    localparam bit SHORT_LD_EN = 1'b0;
`endif

    state_t          state;
    logic [2:0]      cnt;
    logic [2:0]      cnt_inc;
    logic [7:0]      beat_r;
    logic            cycle_end_r;
    logic [OP_W-1:0] op_reg;
    logic [OP_W-1:0] op_next;

    function automatic logic [2:0] last_index(input logic [OP_W-1:0] op);
        if (SHORT_LD_EN && op == OP_LD)
            return 3'(SHORT_LD_LAST);
        return 3'(BEAT_COUNT - 1);
    endfunction

    // cycle_end is registered, so it is computed against the opcode that will be held next cycle.
    assign op_next = bus.ir_valid ? bus.ir_op : op_reg;
    assign cnt_inc = cnt + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= OP_NOP;
        end else if (bus.ir_valid) begin
            op_reg <= bus.ir_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            beat_r      <= 8'd0;
            cycle_end_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state       <= BEAT;
                        cnt         <= 3'd0;
                        beat_r      <= 8'b0000_0001;
                        cycle_end_r <= 1'b0;
                    end
                end
                BEAT: begin
                    // A cycle always runs to its last beat; run only matters there.
                    if (cycle_end_r) begin
                        cnt         <= 3'd0;
                        cycle_end_r <= 1'b0;
                        if (bus.run) begin
                            beat_r <= 8'b0000_0001;
                        end else begin
                            state  <= IDLE;
                            beat_r <= 8'd0;
                        end
                    end else begin
                        cnt         <= cnt_inc;
                        beat_r      <= 8'b0000_0001 << cnt_inc;
                        cycle_end_r <= (cnt_inc >= last_index(op_next));
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= 3'd0;
                    beat_r      <= 8'd0;
                    cycle_end_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.beat      = beat_r;
    assign bus.cycle_end = cycle_end_r;

    op_decode u_op_decode (
        .op      (op_reg),
        .ld      (bus.dec_ld),
        .add     (bus.dec_add),
        .sub     (bus.dec_sub),
        .and_op  (bus.dec_and),
        .or_op   (bus.dec_or),
        .illegal (bus.illegal)
    );

endmodule

// File: tb/tb_timing_gen.sv
// Randomized plus directed bench for timing_gen against a cycle-position reference model.
module tb_timing_gen;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Reference model: whether a cycle is in progress, which beat it is on, and the held opcode.
    bit   m_active;
    int   m_pos;
    int   m_op;

    timing_gen_if bus_if ();

    timing_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cycle_len(input int op);
`ifdef TIMING_SHORT_LD_EN
        if (op == 1) return 6;
`endif
        return 8;
    endfunction

    function automatic logic [4:0] exp_decode(input int op);
        case (op)
            1: return 5'b10000;
            2: return 5'b01000;
            3: return 5'b00100;
            4: return 5'b00010;
            5: return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [7:0] exp_beat;
        logic       exp_end;
        exp_beat = m_active ? (8'd1 << m_pos) : 8'd0;
        exp_end  = m_active && (m_pos >= cycle_len(m_op) - 1);
        checkOutput({tag, " beat"}, 32'(bus_if.beat), 32'(exp_beat));
        checkOutput({tag, " decode"},
                    32'({bus_if.dec_ld, bus_if.dec_add, bus_if.dec_sub, bus_if.dec_and, bus_if.dec_or}),
                    32'(exp_decode(m_op)));
        checkOutput({tag, " cycle_end"}, 32'(bus_if.cycle_end), 32'(exp_end));
        checkOutput({tag, " illegal"}, 32'(bus_if.illegal), 32'(m_op > 5));
    endtask

    // Drive inputs for one clock, advance the model across the edge, then check.
    task automatic applyStimulus(input string tag, input bit run, input bit valid, input int op);
        bit was_last;
        bus_if.run      = run;
        bus_if.ir_valid = valid;
        bus_if.ir_op    = 4'(op);
        @(posedge clk);
        was_last = m_active && (m_pos >= cycle_len(m_op) - 1);
        if (!m_active) begin
            if (run) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (was_last) begin
            m_pos = 0;
            if (!run) m_active = 1'b0;
        end else begin
            m_pos++;
        end
        if (valid) m_op = op;
        #1;
        checkAll(tag);
    endtask

    task automatic modelReset();
        m_active = 1'b0;
        m_pos    = 0;
        m_op     = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        modelReset();
        bus_if.run      = 1'b0;
        bus_if.ir_valid = 1'b0;
        bus_if.ir_op    = 4'h0;
        rst_n = 1'b0;
        #23;
        checkAll("reset");
        rst_n = 1'b1;
        #4;

        // LD cycle back-to-back into a second cycle
        applyStimulus("ld_start", 1'b1, 1'b1, 1);
        for (int i = 0; i < 9; i++) applyStimulus("ld_run", 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) applyStimulus("ld_drain", 1'b0, 1'b0, 0);

        // ADD with run dropped during T3
        applyStimulus("add_start", 1'b1, 1'b1, 2);
        for (int i = 0; i < 3; i++) applyStimulus("add_run", 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) applyStimulus("add_drop", 1'b0, 1'b0, 0);

        // ADD then OR captured at the last beat
        applyStimulus("addor_start", 1'b1, 1'b1, 2);
        for (int i = 0; i < 6; i++) applyStimulus("addor_run", 1'b1, 1'b0, 0);
        applyStimulus("addor_t7", 1'b1, 1'b1, 5);
        for (int i = 0; i < 8; i++) applyStimulus("or_run", 1'b0, 1'b0, 0);

        // Undefined opcode still sequences beats
        applyStimulus("illegal_start", 1'b1, 1'b1, 4'hA);
        for (int i = 0; i < 9; i++) applyStimulus("illegal_run", 1'b0, 1'b0, 0);

        // Legal NOP opcode
        applyStimulus("nop_load", 1'b0, 1'b1, 0);

        // Reset pulsed mid-cycle during T4
        applyStimulus("rst_start", 1'b1, 1'b1, 3);
        for (int i = 0; i < 4; i++) applyStimulus("rst_run", 1'b1, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("rst_async");
        bus_if.run = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus("rst_idle", 1'b0, 1'b0, 0);
        applyStimulus("rst_rerun", 1'b1, 1'b0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random", ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
